// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multicycle MIPS core: holds the fetch address,
// defers taken branches/jumps through one delay slot, and halts at HALT_ADDR.
module pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rt,
  input  logic [5:0]        funct,
  input  logic [15:0]       offset,
  input  logic [25:0]       instr_index,
  input  logic [ADDR_W-1:0] register_data,
  input  logic              zero,
  input  logic              positive,
  input  logic              negative,
  output logic [ADDR_W-1:0] address,
  output logic              active,
  output logic              delay_slot,
  output logic              link_en,
  output logic [ADDR_W-1:0] link_address,
  output logic              target_misaligned
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] HALT_PC    = ADDR_W'(HALT_ADDR);
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;
  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_JALR    = 6'd9;
  localparam logic [4:0] RT_BLTZ    = 5'd0;
  localparam logic [4:0] RT_BGEZ    = 5'd1;
  localparam logic [4:0] RT_BLTZAL  = 5'd16;
  localparam logic [4:0] RT_BGEZAL  = 5'd17;

  typedef enum logic [1:0] {
    SEQ,
    DELAY,
    HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pending;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] target;
  logic              is_jr;
  logic              is_jalr;
  logic              is_j;
  logic              is_jal;
  logic              is_regimm_lt;
  logic              is_regimm_ge;
  logic              is_regimm_al;
  logic              branch_taken;
  logic              transfer;

  assign pc_plus4      = address + ADDR_W'(4);
  assign link_address  = address + ADDR_W'(8);
  assign branch_target = pc_plus4 + {{(ADDR_W-18){offset[15]}}, offset, 2'b00};
  // Upper bits come from the delay-slot address; works down to ADDR_W == 28.
  assign jump_target   = (pc_plus4 & ~LOW28_MASK) | ADDR_W'({instr_index, 2'b00});

  always_comb begin
    is_jr        = (opcode == OP_SPECIAL) && (funct == FN_JR);
    is_jalr      = (opcode == OP_SPECIAL) && (funct == FN_JALR);
    is_j         = (opcode == OP_J);
    is_jal       = (opcode == OP_JAL);
    is_regimm_lt = (opcode == OP_REGIMM) && ((rt == RT_BLTZ) || (rt == RT_BLTZAL));
    is_regimm_ge = (opcode == OP_REGIMM) && ((rt == RT_BGEZ) || (rt == RT_BGEZAL));
    is_regimm_al = (opcode == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));

    branch_taken = 1'b0;
    case (opcode)
      OP_BEQ:    branch_taken = zero;
      OP_BNE:    branch_taken = !zero;
      OP_BLEZ:   branch_taken = zero | negative;
      OP_BGTZ:   branch_taken = positive;
      OP_REGIMM: branch_taken = (is_regimm_lt && negative) || (is_regimm_ge && !negative);
      default:   branch_taken = 1'b0;
    endcase

    transfer = is_jr | is_jalr | is_j | is_jal | branch_taken;

    if (is_jr || is_jalr) begin
      target = register_data;
    end else if (is_j || is_jal) begin
      target = jump_target;
    end else begin
      target = branch_target;
    end

    link_en           = is_jal | is_jalr | is_regimm_al;
    target_misaligned = (is_jr | is_jalr) && (register_data[1:0] != 2'b00);
  end

  // Halt detection overrides a transfer decoded in the same commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEQ;
      address    <= RESET_ADDR;
      pending    <= '0;
      active     <= 1'b1;
      delay_slot <= 1'b0;
    end else if (advance) begin
      case (state)
        SEQ: begin
          address <= pc_plus4;
          if (pc_plus4 == HALT_PC) begin
            state      <= HALTED;
            active     <= 1'b0;
            delay_slot <= 1'b0;
          end else if (transfer) begin
            pending    <= target;
            state      <= DELAY;
            delay_slot <= 1'b1;
          end
        end
        DELAY: begin
          address    <= pending;
          delay_slot <= 1'b0;
          if (pending == HALT_PC) begin
            state  <= HALTED;
            active <= 1'b0;
          end else begin
            state <= SEQ;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= SEQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, directed delay-slot/halt/reset sequences,
// and randomized traffic against a behavioural next-PC model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        advance;
  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [31:0] register_data;
  logic        zero, positive, negative;
  logic [31:0] address;
  logic        active, delay_slot, link_en, target_misaligned;
  logic [31:0] link_address;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'hBFC00000), .HALT_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .advance(advance), .opcode(opcode), .rt(rt),
    .funct(funct), .offset(offset), .instr_index(instr_index),
    .register_data(register_data), .zero(zero), .positive(positive),
    .negative(negative), .address(address), .active(active),
    .delay_slot(delay_slot), .link_en(link_en), .link_address(link_address),
    .target_misaligned(target_misaligned)
  );

  typedef struct {
    logic [5:0]  opc;
    logic [4:0]  rt;
    logic [5:0]  fn;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] rd;
    logic        z, p, n;
    logic        e_link, e_mis, e_ds;
    logic [31:0] e_a2;
  } vec_t;

  vec_t vt[16];

  // behavioural model state
  logic [31:0] m_pc, m_pending;
  bit          m_has_pending, m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_instr(input logic [5:0] opc, input logic [4:0] r, input logic [5:0] fn,
                           input logic [15:0] off, input logic [25:0] idx, input logic [31:0] rd,
                           input logic z, input logic p, input logic n);
    opcode = opc; rt = r; funct = fn; offset = off; instr_index = idx;
    register_data = rd; zero = z; positive = p; negative = n;
  endtask

  task automatic nop();
    set_instr(6'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step(input logic adv);
    advance = adv;
    @(posedge clk);
    #1;
    advance = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    advance = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Spec-level decode: is the instruction a taken transfer, where to, does it link.
  task automatic model_decode(input logic [31:0] pc, output bit taken, output logic [31:0] tgt,
                              output bit link, output bit mis);
    int          sext;
    logic [31:0] pc4;
    bit          jr_like;
    pc4     = pc + 32'd4;
    sext    = $signed(offset);
    tgt     = pc4 + 32'(sext * 4);
    jr_like = (opcode == 0) && (funct == 8 || funct == 9);
    taken   = 0;
    link    = 0;
    if (jr_like) begin
      taken = 1; tgt = register_data; link = (funct == 9);
    end else if (opcode == 2 || opcode == 3) begin
      taken = 1; tgt = {pc4[31:28], instr_index, 2'b00}; link = (opcode == 3);
    end else if (opcode == 4) taken = zero;
    else if (opcode == 5) taken = !zero;
    else if (opcode == 6) taken = zero || negative;
    else if (opcode == 7) taken = positive;
    else if (opcode == 1) begin
      if (rt == 0 || rt == 16) taken = negative;
      else if (rt == 1 || rt == 17) taken = !negative;
      link = (rt == 16 || rt == 17);
    end
    mis = jr_like && (register_data[1:0] != 2'b00);
  endtask

  task automatic rand_instr();
    int sel, s;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1: opcode = 6'd0;
      2: opcode = 6'd1;
      3: opcode = 6'd2;
      4: opcode = 6'd3;
      5: opcode = 6'd4;
      6: opcode = 6'd5;
      7: opcode = 6'd6;
      8: opcode = 6'd7;
      default: opcode = 6'($urandom);
    endcase
    s = $urandom_range(0, 4);
    rt = (s == 0) ? 5'd0 : (s == 1) ? 5'd1 : (s == 2) ? 5'd16 : (s == 3) ? 5'd17 : 5'($urandom);
    s = $urandom_range(0, 3);
    funct = (s == 0) ? 6'd8 : (s == 1) ? 6'd9 : (s == 2) ? 6'd0 : 6'($urandom);
    offset        = 16'($urandom);
    instr_index   = 26'($urandom);
    register_data = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    s = $urandom_range(0, 2);
    zero = (s == 0); positive = (s == 1); negative = (s == 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tgt;
    bit          taken, link, mis;
    logic [31:0] nxt;

    reset = 1'b1;
    advance = 1'b0;
    nop();
    //            opc   rt    fn    off      idx          rd            z p n  lk ms ds  addr after 2 advances
    vt[0]  = '{6'd0, 5'd0, 6'd0, 16'h0000, 26'h0,       32'h0,        0,0,0, 0,0,0, 32'hBFC00008};
    vt[1]  = '{6'd4, 5'd0, 6'd0, 16'h0003, 26'h0,       32'h0,        1,0,0, 0,0,1, 32'hBFC00010};
    vt[2]  = '{6'd4, 5'd0, 6'd0, 16'h0003, 26'h0,       32'h0,        0,1,0, 0,0,0, 32'hBFC00008};
    vt[3]  = '{6'd5, 5'd0, 6'd0, 16'hFFFF, 26'h0,       32'h0,        0,0,1, 0,0,1, 32'hBFC00000};
    vt[4]  = '{6'd5, 5'd0, 6'd0, 16'hFFFF, 26'h0,       32'h0,        1,0,0, 0,0,0, 32'hBFC00008};
    vt[5]  = '{6'd6, 5'd0, 6'd0, 16'h0002, 26'h0,       32'h0,        0,0,1, 0,0,1, 32'hBFC0000C};
    vt[6]  = '{6'd7, 5'd0, 6'd0, 16'h0002, 26'h0,       32'h0,        1,0,0, 0,0,0, 32'hBFC00008};
    vt[7]  = '{6'd1, 5'd16,6'd0, 16'h0001, 26'h0,       32'h0,        0,1,0, 1,0,0, 32'hBFC00008};
    vt[8]  = '{6'd1, 5'd1, 6'd0, 16'h0004, 26'h0,       32'h0,        1,0,0, 0,0,1, 32'hBFC00014};
    vt[9]  = '{6'd1, 5'd2, 6'd0, 16'h0004, 26'h0,       32'h0,        0,0,1, 0,0,0, 32'hBFC00008};
    vt[10] = '{6'd2, 5'd0, 6'd0, 16'h0000, 26'h0000100, 32'h0,        0,0,0, 0,0,1, 32'hB0000400};
    vt[11] = '{6'd3, 5'd0, 6'd0, 16'h0000, 26'h3FFFFFF, 32'h0,        0,0,0, 1,0,1, 32'hBFFFFFFC};
    vt[12] = '{6'd0, 5'd0, 6'd8, 16'h0000, 26'h0,       32'hBFC00102, 0,0,0, 0,1,1, 32'hBFC00102};
    vt[13] = '{6'd0, 5'd0, 6'd9, 16'h0000, 26'h0,       32'h00001000, 0,0,0, 1,0,1, 32'h00001000};
    vt[14] = '{6'd0, 5'd0, 6'd10,16'h0000, 26'h0,       32'h00000003, 0,0,0, 0,0,0, 32'hBFC00008};
    vt[15] = '{6'd1, 5'd17,6'd0, 16'h0004, 26'h0,       32'h0,        0,0,1, 1,0,0, 32'hBFC00008};

    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_address", address, 32'hBFC00000);
    chk("reset_active", 32'(active), 32'd1);
    chk("reset_delay_slot", 32'(delay_slot), 32'd0);

    // sequential NOPs
    for (int i = 1; i <= 3; i++) begin
      step(1'b1);
      chk("nop_address", address, 32'hBFC00000 + 32'(4 * i));
      chk("nop_active", 32'(active), 32'd1);
      chk("nop_delay_slot", 32'(delay_slot), 32'd0);
    end

    // vector table, each from a fresh reset at BFC00000
    for (int i = 0; i < 16; i++) begin
      do_reset();
      set_instr(vt[i].opc, vt[i].rt, vt[i].fn, vt[i].off, vt[i].idx, vt[i].rd,
                vt[i].z, vt[i].p, vt[i].n);
      #1;
      chk("vec_link_en", 32'(link_en), 32'(vt[i].e_link));
      chk("vec_link_address", link_address, 32'hBFC00008);
      chk("vec_misaligned", 32'(target_misaligned), 32'(vt[i].e_mis));
      step(1'b1);
      chk("vec_addr1", address, 32'hBFC00004);
      chk("vec_ds1", 32'(delay_slot), 32'(vt[i].e_ds));
      nop();
      step(1'b1);
      chk("vec_addr2", address, vt[i].e_a2);
      chk("vec_ds2", 32'(delay_slot), 32'd0);
      chk("vec_active2", 32'(active), 32'd1);
    end

    // JALR to the halt address, then advances are ignored
    do_reset();
    nop();
    for (int i = 0; i < 8; i++) step(1'b1);
    chk("jalr_pc", address, 32'hBFC00020);
    set_instr(6'd0, 5'd0, 6'd9, 16'h0, 26'h0, 32'h0, 0, 0, 0);
    #1;
    chk("jalr_link_en", 32'(link_en), 32'd1);
    chk("jalr_link_address", link_address, 32'hBFC00028);
    step(1'b1);
    nop();
    step(1'b1);
    chk("halt_address", address, 32'h0);
    chk("halt_active", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("halted_address", address, 32'h0);
    chk("halted_active", 32'(active), 32'd0);

    // JAL in the delay slot of a taken BGEZAL is ignored
    do_reset();
    set_instr(6'd1, 5'd17, 6'd0, 16'h0008, 26'h0, 32'h0, 0, 1, 0);
    #1;
    chk("bgezal_link_en", 32'(link_en), 32'd1);
    step(1'b1);
    chk("bgezal_ds", 32'(delay_slot), 32'd1);
    set_instr(6'd3, 5'd0, 6'd0, 16'h0, 26'h0000040, 32'h0, 0, 0, 0);
    #1;
    chk("slot_jal_link_en", 32'(link_en), 32'd1);
    step(1'b1);
    chk("bgezal_target", address, 32'hBFC00024);
    chk("bgezal_ds_clear", 32'(delay_slot), 32'd0);

    // advance low holds DELAY while inputs churn; then reset discards pending
    do_reset();
    set_instr(6'd0, 5'd0, 6'd8, 16'h0, 26'h0, 32'hBFC00102, 0, 0, 0);
    step(1'b1);
    for (int i = 0; i < 5; i++) begin
      rand_instr();
      step(1'b0);
    end
    chk("hold_address", address, 32'hBFC00004);
    chk("hold_ds", 32'(delay_slot), 32'd1);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    chk("reset_in_delay_address", address, 32'hBFC00000);
    chk("reset_in_delay_ds", 32'(delay_slot), 32'd0);
    nop();
    step(1'b1);
    chk("after_reset_seq", address, 32'hBFC00004);

    // randomized traffic against the model
    do_reset();
    m_pc = 32'hBFC00000; m_pending = '0; m_has_pending = 0; m_halted = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset   = ($urandom_range(0, 60) == 0);
      advance = ($urandom_range(0, 3) != 0);
      rand_instr();
      #1;
      model_decode(m_pc, taken, tgt, link, mis);
      chk("rnd_address", address, m_pc);
      chk("rnd_active", 32'(active), 32'(!m_halted));
      chk("rnd_delay_slot", 32'(delay_slot), 32'(m_has_pending));
      chk("rnd_link_en", 32'(link_en), 32'(link));
      chk("rnd_link_address", link_address, m_pc + 32'd8);
      chk("rnd_misaligned", 32'(target_misaligned), 32'(mis));
      if (reset) begin
        m_pc = 32'hBFC00000; m_pending = '0; m_has_pending = 0; m_halted = 0;
      end else if (advance && !m_halted) begin
        if (m_has_pending) begin
          nxt = m_pending;
          m_has_pending = 0;
        end else begin
          nxt = m_pc + 32'd4;
          if (taken) begin
            m_pending = tgt;
            m_has_pending = 1;
          end
        end
        m_pc = nxt;
        if (nxt == 32'h0) begin
          m_halted = 1;
          m_has_pending = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    advance = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
